sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Slot-based arbiter and sequencer for the shared external video/main SRAM. Three requesters share it: the video fetcher (read-only, deadline-critical), the CPU memory path, and the ULAplus palette port (read/write). It runs each granted access as a fixed-length SRAM cycle on clk28, returns read data with a completion strobe, and guarantees bounded wait to lower-priority requesters.

## Interface
- STARVE_LIMIT, 3, consecutive lost arbitrations after which a waiting requester is promoted above video (1..7)
- clk28  in  1  system clock, 28 MHz
- usrrst_n  in  1  asynchronous, active-low reset
- vid_req / vid_addr  in  1 / 19  video read request (level) and address
- vid_ack / vid_done  out  1 / 1  grant pulse / read-complete pulse
- cpu_req, cpu_we / cpu_addr / cpu_wdata  in  1,1 / 19 / 8  CPU request, write enable, address, write data
- cpu_ack / cpu_done  out  1 / 1  grant pulse / complete pulse
- up_req, up_we / up_addr / up_wdata  in  1,1 / 19 / 8  ULAplus request, write enable, address, write data
- up_ack / up_done  out  1 / 1  grant pulse / complete pulse
- rd_data  out  8  last read data; valid with any *_done of a read
- sram_a  out  19  SRAM address
- sram_d_in  in  8  SRAM data from pins
- sram_d_out / sram_d_oe  out  8 / 1  SRAM write data / pin output enable
- sram_n_rd, sram_n_wr  out  1  SRAM strobes, active low
- busy  out  1  high in every non-IDLE state

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B, WR_H.
- Arbitration point (AP): the clock edge that leaves IDLE, RD_B or WR_H. At the AP, the winner's addr/we/wdata are latched, the next state is RD_A (read) or WR_A (write), and the winner's *_ack pulses for exactly the RD_A/WR_A cycle. If there is no request, go to IDLE.
- Priority: video > cpu > up. Exception: a counter at STARVE_LIMIT beats video. If both cpu and up are promoted, cpu wins.
- Starve counters (3 bit, one each for cpu and up): at each AP, +1 (saturating at STARVE_LIMIT) if req is high and the requester was not granted. Clear on grant or when req is low.
- The source granted at an AP has its req masked at the next AP, so a requester needs one cycle after ack to drop req. The video fetcher never writes.
- Read: RD_A drives sram_a with n_rd=0. RD_B holds them, and sram_d_in is captured into rd_data at the end of RD_B.
- Write:
  - WR_A drives sram_a/sram_d_out with d_oe=1 and n_wr=1.
  - WR_B: n_wr=0.
  - WR_H: n_wr=1, address and data held, d_oe=1.
  - d_oe drops on leaving WR_H.
- Completion: *_done pulses 1 cycle, in the cycle after RD_B or WR_H. rd_data holds until the next read completes and is unaffected by writes.
- A req dropped before its AP produces no access and no ack.

## Timing
- Read slot: 2 cycles. Write slot: 3 cycles. Back-to-back slots run with no idle cycle.
- From IDLE, a request seen high at edge t gives: ack in cycle t+1, strobe in cycles t+1..t+2 (read), done/rd_data in cycle t+3.
- Worst-case cpu wait under continuous video: STARVE_LIMIT+1 slots. up wait is bounded by 2*(STARVE_LIMIT+1) slots.
- Reset values (async assertion takes effect immediately, including mid-access):
  - state=IDLE, sram_a=0, sram_d_out=0, d_oe=0, n_rd=1, n_wr=1, rd_data=0, all ack/done=0, counters=0, busy=0.
  - An aborted access never produces done.
- Strobes are glitch-free registered outputs. n_wr never falls in the same cycle that sram_a or sram_d_out changes.

## Test plan
- cpu read 0x12345, SRAM model returns 0xA5. Required: cpu_ack 1 cycle after req, n_rd low for 2 cycles, cpu_done plus rd_data=0xA5 on the 3rd cycle, busy low afterward.
- vid_req and cpu_req rise in the same cycle. Required: video granted first, cpu granted at the next AP (RD_B), both dones exactly 2 cycles apart.
- vid_req held high continuously plus cpu_req, STARVE_LIMIT=3. Required: cpu granted on the 4th AP, then video resumes.
- up write 0x3F to 0x0C040. Required: d_oe high for 3 cycles, n_wr low only in the middle cycle, sram_a stable across all three, up_done afterward, rd_data unchanged.
- usrrst_n asserted during WR_B. Required: n_wr=1 and d_oe=0 immediately, no up_done, and after release the first request is served normally.
- Alternating cpu write / up read / video read, each re-requested 1 cycle after ack. Required: slots of lengths 3, 2, 2 with no idle cycle, and the masked source is not re-granted at the immediately following AP.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Slot-based arbiter/sequencer for the shared video/main SRAM.
//               Video > CPU > ULAplus, with starve counters that promote a
//               long-waiting CPU or ULAplus request above video.
// Revision    : 1.0  initial release
// ============================================================================
module sram_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk28,
    input  logic        usrrst_n,
    input  logic        vid_req,
    input  logic [18:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_done,
    input  logic        up_req,
    input  logic        up_we,
    input  logic [18:0] up_addr,
    input  logic [7:0]  up_wdata,
    output logic        up_ack,
    output logic        up_done,
    output logic [7:0]  rd_data,
    output logic [18:0] sram_a,
    input  logic [7:0]  sram_d_in,
    output logic [7:0]  sram_d_out,
    output logic        sram_d_oe,
    output logic        sram_n_rd,
    output logic        sram_n_wr,
    output logic        busy
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_B = 3'd2;
    localparam logic [2:0] WR_A = 3'd3;
    localparam logic [2:0] WR_B = 3'd4;
    localparam logic [2:0] WR_H = 3'd5;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_VID  = 2'd1;
    localparam logic [1:0] SRC_CPU  = 2'd2;
    localparam logic [1:0] SRC_UP   = 2'd3;

    localparam logic [2:0] LIMIT = STARVE_LIMIT[2:0];

    logic [2:0]  state;
    logic [1:0]  slot_src;     // source granted at the most recent AP
    logic [2:0]  cpu_cnt;
    logic [2:0]  up_cnt;

    logic        at_ap;
    logic        cpu_eff;
    logic        up_eff;
    logic        cpu_prom;
    logic        up_prom;
    logic [1:0]  winner;
    logic        win_we;
    logic [18:0] win_addr;
    logic [7:0]  win_wdata;

    assign busy = (state != IDLE);

    // Arbitration: mask the previous winner, apply starvation promotion, then
    // fixed priority. Video streams with a level request and is never masked,
    // otherwise it would lose every other slot.
    always_comb begin
        at_ap     = (state == IDLE) || (state == RD_B) || (state == WR_H);
        cpu_eff   = cpu_req && (slot_src != SRC_CPU);
        up_eff    = up_req  && (slot_src != SRC_UP);
        cpu_prom  = cpu_eff && (cpu_cnt >= LIMIT);
        up_prom   = up_eff  && (up_cnt  >= LIMIT);
        winner    = SRC_NONE;
        win_we    = 1'b0;
        win_addr  = 19'd0;
        win_wdata = 8'd0;
        if (cpu_prom)
            winner = SRC_CPU;
        else if (up_prom)
            winner = SRC_UP;
        else if (vid_req)
            winner = SRC_VID;
        else if (cpu_eff)
            winner = SRC_CPU;
        else if (up_eff)
            winner = SRC_UP;
        case (winner)
            SRC_VID: begin
                win_addr  = vid_addr;
            end
            SRC_CPU: begin
                win_we    = cpu_we;
                win_addr  = cpu_addr;
                win_wdata = cpu_wdata;
            end
            SRC_UP: begin
                win_we    = up_we;
                win_addr  = up_addr;
                win_wdata = up_wdata;
            end
            default: ;
        endcase
    end

    // Slot sequencer: strobes, data capture, acks/dones and starve counters.
    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            state      <= IDLE;
            slot_src   <= SRC_NONE;
            cpu_cnt    <= 3'd0;
            up_cnt     <= 3'd0;
            sram_a     <= 19'd0;
            sram_d_out <= 8'd0;
            sram_d_oe  <= 1'b0;
            sram_n_rd  <= 1'b1;
            sram_n_wr  <= 1'b1;
            rd_data    <= 8'd0;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            up_ack     <= 1'b0;
            vid_done   <= 1'b0;
            cpu_done   <= 1'b0;
            up_done    <= 1'b0;
        end else begin
            vid_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            up_ack   <= 1'b0;
            vid_done <= 1'b0;
            cpu_done <= 1'b0;
            up_done  <= 1'b0;

            case (state)
                RD_A: state <= RD_B;
                WR_A: begin
                    state     <= WR_B;
                    sram_n_wr <= 1'b0;
                end
                WR_B: begin
                    state     <= WR_H;
                    sram_n_wr <= 1'b1;
                end
                default: ;
            endcase

            if (at_ap) begin
                // Finish the slot that is ending here, if any.
                if (state == RD_B)
                    rd_data <= sram_d_in;
                if (state == RD_B || state == WR_H) begin
                    vid_done <= (slot_src == SRC_VID);
                    cpu_done <= (slot_src == SRC_CPU);
                    up_done  <= (slot_src == SRC_UP);
                end

                slot_src <= winner;

                if (!cpu_eff || winner == SRC_CPU)
                    cpu_cnt <= 3'd0;
                else if (cpu_cnt < LIMIT)
                    cpu_cnt <= cpu_cnt + 3'd1;

                if (!up_eff || winner == SRC_UP)
                    up_cnt <= 3'd0;
                else if (up_cnt < LIMIT)
                    up_cnt <= up_cnt + 3'd1;

                if (winner == SRC_NONE) begin
                    state     <= IDLE;
                    sram_n_rd <= 1'b1;
                    sram_d_oe <= 1'b0;
                end else begin
                    sram_a  <= win_addr;
                    vid_ack <= (winner == SRC_VID);
                    cpu_ack <= (winner == SRC_CPU);
                    up_ack  <= (winner == SRC_UP);
                    if (win_we) begin
                        state      <= WR_A;
                        sram_d_out <= win_wdata;
                        sram_d_oe  <= 1'b1;
                        sram_n_rd  <= 1'b1;
                    end else begin
                        state      <= RD_A;
                        sram_d_oe  <= 1'b0;
                        sram_n_rd  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk28 = 1'b0;
    logic        usrrst_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [18:0] vid_addr = 19'd0;
    logic        vid_ack, vid_done;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [18:0] cpu_addr = 19'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic        cpu_ack, cpu_done;
    logic        up_req = 1'b0, up_we = 1'b0;
    logic [18:0] up_addr = 19'd0;
    logic [7:0]  up_wdata = 8'd0;
    logic        up_ack, up_done;
    logic [7:0]  rd_data;
    logic [18:0] sram_a;
    logic [7:0]  sram_d_in;
    logic [7:0]  sram_d_out;
    logic        sram_d_oe, sram_n_rd, sram_n_wr, busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] saved_rd;

    always #18 clk28 = ~clk28;

    // SRAM contents: one fixed cell, everything else an address hash.
    function automatic logic [7:0] sram_model(input logic [18:0] a);
        if (a == 19'h12345)
            return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    assign sram_d_in = sram_model(sram_a);

    sram_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk28(clk28), .usrrst_n(usrrst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_done(vid_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_done(cpu_done),
        .up_req(up_req), .up_we(up_we), .up_addr(up_addr), .up_wdata(up_wdata),
        .up_ack(up_ack), .up_done(up_done),
        .rd_data(rd_data), .sram_a(sram_a), .sram_d_in(sram_d_in),
        .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe),
        .sram_n_rd(sram_n_rd), .sram_n_wr(sram_n_wr), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk28);
    endtask

    initial begin
        // ---------------- reset values ----------------
        repeat (2) cyc();
        check("rst_busy", busy, 0);
        check("rst_nrd", sram_n_rd, 1);
        check("rst_nwr", sram_n_wr, 1);
        check("rst_oe", sram_d_oe, 0);
        check("rst_a", sram_a, 0);
        check("rst_dout", sram_d_out, 0);
        check("rst_rd", rd_data, 0);
        check("rst_acks", {vid_ack, cpu_ack, up_ack, vid_done, cpu_done, up_done}, 0);
        usrrst_n = 1'b1;
        repeat (2) cyc();

        // ---------------- 1: cpu read 0x12345 ----------------
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h12345;
        cyc();
        check("t1_ack", cpu_ack, 1);
        check("t1_nrd_a", sram_n_rd, 0);
        check("t1_addr", sram_a, 19'h12345);
        check("t1_busy", busy, 1);
        cpu_req = 0;
        cyc();
        check("t1_ack_b", cpu_ack, 0);
        check("t1_nrd_b", sram_n_rd, 0);
        check("t1_done_early", cpu_done, 0);
        cyc();
        check("t1_done", cpu_done, 1);
        check("t1_rd", rd_data, 8'hA5);
        check("t1_nrd_c", sram_n_rd, 1);
        check("t1_idle", busy, 0);
        cyc();
        check("t1_done_pulse", cpu_done, 0);

        // ---------------- 2: video and cpu together ----------------
        vid_req = 1; vid_addr = 19'h04321;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00100;
        cyc();
        check("t2_vack", vid_ack, 1);
        check("t2_cack0", cpu_ack, 0);
        check("t2_vaddr", sram_a, 19'h04321);
        vid_req = 0;
        cyc();
        cyc();
        check("t2_cack", cpu_ack, 1);
        check("t2_vdone", vid_done, 1);
        check("t2_cdone0", cpu_done, 0);
        check("t2_vrd", rd_data, sram_model(19'h04321));
        cpu_req = 0;
        cyc();
        cyc();
        check("t2_cdone", cpu_done, 1);
        check("t2_vdone0", vid_done, 0);
        check("t2_crd", rd_data, sram_model(19'h00100));
        cyc();

        // ---------------- 3: starvation promotion ----------------
        vid_req = 1; vid_addr = 19'h05000;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h06000;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check("t3_vack", vid_ack, 1);
            check("t3_cack0", cpu_ack, 0);
            cyc();
        end
        cyc();
        check("t3_cack", cpu_ack, 1);
        check("t3_vack0", vid_ack, 0);
        check("t3_caddr", sram_a, 19'h06000);
        cpu_req = 0;
        cyc();
        cyc();
        check("t3_vresume", vid_ack, 1);
        check("t3_cdone", cpu_done, 1);
        check("t3_crd", rd_data, sram_model(19'h06000));
        vid_req = 0;
        cyc();
        cyc();
        check("t3_vdone", vid_done, 1);
        check("t3_idle", busy, 0);

        // ---------------- 4: ULAplus write ----------------
        saved_rd = rd_data;
        up_req = 1; up_we = 1; up_addr = 19'h0C040; up_wdata = 8'h3F;
        cyc();
        check("t4_ack", up_ack, 1);
        check("t4_oe_a", sram_d_oe, 1);
        check("t4_nwr_a", sram_n_wr, 1);
        check("t4_addr_a", sram_a, 19'h0C040);
        check("t4_dout", sram_d_out, 8'h3F);
        check("t4_nrd", sram_n_rd, 1);
        up_req = 0;
        cyc();
        check("t4_oe_b", sram_d_oe, 1);
        check("t4_nwr_b", sram_n_wr, 0);
        check("t4_addr_b", sram_a, 19'h0C040);
        cyc();
        check("t4_oe_h", sram_d_oe, 1);
        check("t4_nwr_h", sram_n_wr, 1);
        check("t4_addr_h", sram_a, 19'h0C040);
        check("t4_dout_h", sram_d_out, 8'h3F);
        check("t4_done0", up_done, 0);
        cyc();
        check("t4_done", up_done, 1);
        check("t4_oe_off", sram_d_oe, 0);
        check("t4_rd_keep", rd_data, saved_rd);
        check("t4_idle", busy, 0);

        // ---------------- 5: reset during WR_B ----------------
        up_req = 1; up_we = 1; up_addr = 19'h00AAA; up_wdata = 8'h11;
        cyc();
        up_req = 0;
        cyc();
        check("t5_in_wrb", sram_n_wr, 0);
        #5 usrrst_n = 1'b0;
        #1;
        check("t5_nwr", sram_n_wr, 1);
        check("t5_oe", sram_d_oe, 0);
        check("t5_busy", busy, 0);
        check("t5_rd", rd_data, 0);
        cyc();
        usrrst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t5_nodone", up_done, 0);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h12345;
        cyc();
        check("t5_ack", cpu_ack, 1);
        cpu_req = 0;
        cyc();
        cyc();
        check("t5_done", cpu_done, 1);
        check("t5_rdv", rd_data, 8'hA5);

        // ---------------- 6: cpu W / up R / video R back to back ----------------
        cyc();
        cpu_req = 1; cpu_we = 1; cpu_addr = 19'h01000; cpu_wdata = 8'h77;
        cyc();                                   // WR_A
        check("t6_cack", cpu_ack, 1);
        check("t6_oe", sram_d_oe, 1);
        cpu_req = 0;
        up_req = 1; up_we = 0; up_addr = 19'h02000;
        cyc();                                   // WR_B
        check("t6_busy_b", busy, 1);
        cpu_req = 1;
        cyc();                                   // WR_H
        check("t6_busy_h", busy, 1);
        check("t6_nwr_h", sram_n_wr, 1);
        cyc();                                   // up RD_A
        check("t6_uack", up_ack, 1);
        check("t6_masked", cpu_ack, 0);
        check("t6_cdone", cpu_done, 1);
        check("t6_uaddr", sram_a, 19'h02000);
        check("t6_unrd", sram_n_rd, 0);
        up_req = 0;
        vid_req = 1; vid_addr = 19'h03000;
        cyc();                                   // up RD_B
        up_req = 1;
        cyc();                                   // video RD_A
        check("t6_vack", vid_ack, 1);
        check("t6_umasked", up_ack, 0);
        check("t6_cack0", cpu_ack, 0);
        check("t6_udone", up_done, 1);
        check("t6_urd", rd_data, sram_model(19'h02000));
        vid_req = 0; cpu_req = 0; up_req = 0;
        cyc();                                   // video RD_B
        check("t6_busy_vb", busy, 1);
        cyc();
        check("t6_vdone", vid_done, 1);
        check("t6_vrd", rd_data, sram_model(19'h03000));
        check("t6_idle", busy, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
